// File: rtl/bcd_count_multi_if.sv
// Control/status bundle for bcd_count_multi: count controls and load value in,
// registered count plus terminal-count, wrap and zero flags out.
interface bcd_count_multi_if #(
   parameter int unsigned DIGITS = 4
);
   logic                  en;
   logic                  up_dn;
   logic                  LD;
   logic [4*DIGITS-1:0]   D;
   logic [4*DIGITS-1:0]   data;
   logic                  tc;
   logic                  wrap;
   logic                  zero;

   modport master (output en, up_dn, LD, D, input data, tc, wrap, zero);
   modport slave  (input en, up_dn, LD, D, output data, tc, wrap, zero);
endinterface

// File: rtl/bcd_count_multi.sv
// Cascaded up/down BCD counter with parallel load, terminal count and wrap pulse.
// Define BCD_LOAD_CLAMP_EN to clamp loaded digits above 9 down to 9.
module bcd_count_multi #(
   parameter int unsigned DIGITS = 4
) (
   input logic               clk,
   input logic               reset,
   bcd_count_multi_if.slave  bus
);
   localparam int unsigned W = 4 * DIGITS;

   logic [W-1:0] data_q, data_d;
   logic [W-1:0] load_val;
   logic [W-1:0] cnt_val;
   logic         wrap_q, wrap_d;
   logic         all9, all0;
   logic         tc;

   always_comb begin
      all9 = 1'b1;
      all0 = 1'b1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (data_q[4*k +: 4] != 4'd9) all9 = 1'b0;
         if (data_q[4*k +: 4] != 4'd0) all0 = 1'b0;
      end
   end

   assign tc = bus.en & ~bus.LD & ~reset & (bus.up_dn ? all0 : all9);

   always_comb begin
      load_val = bus.D;
`ifdef BCD_LOAD_CLAMP_EN
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (bus.D[4*k +: 4] > 4'd9) load_val[4*k +: 4] = 4'd9;
      end
`endif
   end

   // Carry/borrow chain resolved combinationally so every digit settles in one edge;
   // carry passes through any digit >= 9, borrow only through digits equal to 0.
   always_comb begin : count_chain
      logic       chain;
      logic [3:0] dig;
      chain   = 1'b1;
      cnt_val = data_q;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         dig = data_q[4*k +: 4];
         if (chain) begin
            if (!bus.up_dn) begin
               if (dig >= 4'd9) begin
                  cnt_val[4*k +: 4] = 4'd0;
               end else begin
                  cnt_val[4*k +: 4] = dig + 4'd1;
                  chain = 1'b0;
               end
            end else begin
               if (dig == 4'd0) begin
                  cnt_val[4*k +: 4] = 4'd9;
               end else begin
                  cnt_val[4*k +: 4] = dig - 4'd1;
                  chain = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      data_d = data_q;
      wrap_d = 1'b0;
      if (reset) begin
         data_d = '0;
      end else if (bus.LD) begin
         data_d = load_val;
      end else if (bus.en) begin
         data_d = cnt_val;
         wrap_d = tc;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
      wrap_q <= wrap_d;
   end

   assign bus.data = data_q;
   assign bus.tc   = tc;
   assign bus.wrap = wrap_q;
   assign bus.zero = reset | all0;
endmodule

// File: doc/bcd_count_multi.md
BCD_COUNT_MULTI -- requirements
Module: bcd_count_multi

Interface
REQ-001 Parameter DIGITS, default 4, number of cascaded BCD digits (legal range 1..8).
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 en  input  1  count enable; 1 = count, 0 = hold.
REQ-005 up_dn  input  1  direction; 0 = count up, 1 = count down.
REQ-006 LD  input  1  synchronous parallel load.
REQ-007 D  input  4*DIGITS  load value; digit k occupies bits [4k+3:4k], digit 0 is least significant.
REQ-008 data  output  4*DIGITS  registered count value, same digit packing as D.
REQ-009 tc  output  1  combinational terminal count, for cascading.
REQ-010 wrap  output  1  registered one-cycle pulse on a full-counter wrap.
REQ-011 zero  output  1  combinational flag; 1 when every digit of data equals 0.

Function
REQ-012 Updates occur only on a rising clk edge; priority order is reset > LD > en > hold.
REQ-013 LD=1: data <= D in the same edge, regardless of en and up_dn; wrap <= 0.
REQ-014 en=0 and LD=0: data holds and wrap <= 0.
REQ-015 Up count: digit 0 increments every enabled cycle; digit k increments only when digits 0..k-1 are all 9.
- A digit that would increment from 9 or above becomes 0 and carries into digit k+1.
REQ-016 Down count: digit 0 decrements every enabled cycle; digit k decrements only when digits 0..k-1 are all 0.
- A digit that would decrement from 0 becomes 9 and borrows from digit k+1.
REQ-017 An out-of-range digit (10..15) held in data behaves as follows.
- Up: treated as 9, so it becomes 0 with carry.
- Down: decrements by 1 with no borrow, e.g. 12 -> 11.
REQ-018 The whole counter update completes in a single cycle: no ripple latency and no intermediate values on data.
REQ-019 tc = en & ~LD & ~reset & (up_dn ? all digits 0 : all digits 9).
REQ-020 wrap <= 1 on the edge where the counter advances while tc=1.
- Up: all-9 -> all-0.
- Down: all-0 -> all-9.
- wrap returns to 0 on the next edge unless the wrap condition repeats.
REQ-021 A direction change takes effect on the next enabled edge with no extra cycle; the counter continues from its current value.
REQ-022 LD and en both 1 in the same cycle: load wins, no count, wrap <= 0.

Reset
REQ-023 With reset=1 at a rising edge: data <= 0 (all digits) and wrap <= 0, overriding LD and en.
REQ-024 Reset asserted mid-count aborts any pending wrap; after release, counting resumes from 0 on the first enabled edge.
REQ-025 zero=1 and tc=0 while reset=1.

Configuration
REQ-026 Macro BCD_LOAD_CLAMP_EN controls load clamping.
- Defined: during LD, each digit of D greater than 9 is stored as 9; digits 0..9 are stored unchanged.
- Undefined: D is stored raw, and out-of-range digits follow REQ-017.

Verification
REQ-027 DIGITS=4: reset, then en=1, up_dn=0 for 10 cycles -> data=0x0010; wrap=0 throughout.
REQ-028 Load D=0x9998, en=1, up_dn=0.
- Edge 1 -> 0x9999 with tc=1.
- Edge 2 -> 0x0000 with wrap=1 for exactly one cycle.
REQ-029 Load 0x0001, up_dn=1, en=1.
- Edge 1 -> 0x0000, zero=1, tc=1.
- Edge 2 -> 0x9999, wrap=1.
REQ-030 Value 0x0509 with LD=1, en=1, D=0x1234 -> 0x1234 and no count; next edge with en=0 -> holds 0x1234.
REQ-031 Load D=0x00F0.
- With BCD_LOAD_CLAMP_EN: data=0x0090.
- Without it: data=0x00F0; one up count -> 0x00F1; nine more -> 0x0100.
REQ-032 Counting at 0x0999 with reset=1, LD=1, en=1 together -> data=0x0000, wrap=0.
